booth_mul_arbiter: RTL and testbench

- Shares one sequential 5x5 Booth multiplier datapath among NREQ requesters using round-robin arbitration.
- Sequences the datapath: latches the granted operands, pulses mul_start, waits a fixed latency, captures mul_result and returns it to the owning requester over a valid/ready response.
- Sits between requester blocks and the multiplier instance; the multiplier is treated as opaque, with fixed latency and no done flag.

---
 rtl/booth_mul_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// -----------------
// Shares one sequential Booth multiplier among NREQ requesters with
// round-robin arbitration. The multiplier has a fixed latency and no
// done flag. Each job goes through these steps:
//   1. Grant one requester and latch its operands.
//   2. Pulse mul_start for one cycle.
//   3. Wait MUL_LAT cycles.
//   4. Capture mul_result.
//   5. Present the result to the owner over a valid/ready response.
//
// Ports
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   req[NREQ]           request levels, held by each requester until its grant
//   req_m/req_q         packed operands, requester i at [i*OW +: OW]
//   gnt[NREQ]           one-hot single-cycle grant, combinational in IDLE
//   rsp_valid[NREQ]     one-hot response valid, for the owner of rsp_result
//   rsp_result[RW]      product returned to the owner
//   rsp_ready[NREQ]     response accept; only the owner's bit is looked at
//   busy                high whenever the FSM is not in IDLE
//   mul_start           start pulse to the multiplier
//   mul_m/mul_q         registered operands to the multiplier
//   mul_result[RW]      multiplier product
//
// Optional build macro: BOOTH_ARB_ZERO_BYPASS_EN.
//   When it is defined, a job whose granted multiplicand or multiplier is
//   zero goes straight to RESP with a zero result and never starts the
//   multiplier.

module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int OW      = 5,
    parameter int RW      = 8,
    parameter int MUL_LAT = 6
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*OW-1:0] req_m,
    input  logic [NREQ*OW-1:0] req_q,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [RW-1:0]      rsp_result,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic               busy,
    output logic               mul_start,
    output logic [OW-1:0]      mul_m,
    output logic [OW-1:0]      mul_q,
    input  logic [RW-1:0]      mul_result
);

    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   owner_reg;
    logic [CW-1:0]   cnt_reg;
    logic [OW-1:0]   mul_m_reg, mul_q_reg;
    logic [RW-1:0]   rsp_result_reg;

    // Unpacked operands and the mask of requesters strictly above the pointer
    logic [OW-1:0]   op_m [NREQ];
    logic [OW-1:0]   op_q [NREQ];
    logic [NREQ-1:0] above_mask;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] pick_vec;
    logic [PW-1:0]   win_idx;
    logic [OW-1:0]   win_m, win_q;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_m[gi]       = req_m[gi*OW +: OW];
            assign op_q[gi]       = req_q[gi*OW +: OW];
            assign above_mask[gi] = (PW'(gi) > ptr_reg);
        end
    endgenerate

    // Round-robin: the lowest request above the pointer wins. If there is
    // none, wrap around and take the lowest request overall.
    assign req_hi   = req & above_mask;
    assign pick_vec = (|req_hi) ? req_hi : req;

    always_comb begin
        win_idx = '0;
        // Scan downwards so the lowest set bit is the last one written
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pick_vec[k]) begin
                win_idx = PW'(k);
            end
        end
    end

    assign win_m = op_m[win_idx];
    assign win_q = op_q[win_idx];

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (win_m == '0) || (win_q == '0);
`endif

    // Next state and combinational outputs
    always_comb begin
        state_next = state_reg;
        gnt        = '0;
        rsp_valid  = '0;
        mul_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt[win_idx] = 1'b1;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
                    state_next = zero_op ? RESP : LAUNCH;
`else
                    state_next = LAUNCH;
`endif
                end
            end
            LAUNCH: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_reg] = 1'b1;
                if (rsp_ready[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // The FSM rests in IDLE during reset. Without this gate, a held
        // req would still produce a grant while n_rst is low.
        if (!n_rst) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= PW'(NREQ - 1);
            owner_reg      <= '0;
            cnt_reg        <= '0;
            mul_m_reg      <= '0;
            mul_q_reg      <= '0;
            rsp_result_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        mul_m_reg <= win_m;
                        mul_q_reg <= win_q;
                        owner_reg <= win_idx;
                        ptr_reg   <= win_idx;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
                        if (zero_op) begin
                            rsp_result_reg <= '0;
                        end
`endif
                    end
                end
                LAUNCH: cnt_reg <= '0;
                WAIT: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CNT_LAST) begin
                        rsp_result_reg <= mul_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign mul_m      = mul_m_reg;
    assign mul_q      = mul_q_reg;
    assign rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Testbench for booth_mul_arbiter.
// A job-level reference model predicts the DUT outputs every cycle.
// Directed scenarios add hand-computed expectations.
// A stub multiplier presents the product only in the single cycle in which
// it is valid, so a capture on the wrong cycle returns a wrong value.
`timescale 1ns/1ps
module tb_booth_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int OW      = 5;
    localparam int RW      = 8;
    localparam int MUL_LAT = 6;

    logic                clk = 1'b0;
    logic                n_rst;
    logic [NREQ-1:0]     req, gnt, rsp_valid, rsp_ready;
    logic [NREQ*OW-1:0]  req_m, req_q;
    logic [RW-1:0]       rsp_result, mul_result;
    logic                busy, mul_start;
    logic [OW-1:0]       mul_m, mul_q;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    booth_mul_arbiter #(.NREQ(NREQ), .OW(OW), .RW(RW), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_m(req_m), .req_q(req_q),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready), .busy(busy), .mul_start(mul_start),
        .mul_m(mul_m), .mul_q(mul_q), .mul_result(mul_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Stub multiplier: the product is valid only in the MUL_LAT-th cycle after mul_start
    int          stub_cnt;
    logic [RW-1:0] stub_prod;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stub_cnt  <= 0;
            stub_prod <= '0;
        end else if (mul_start) begin
            stub_cnt  <= MUL_LAT;
            stub_prod <= RW'(int'(mul_m) * int'(mul_q));
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign mul_result = (stub_cnt == 1) ? stub_prod : 8'hEE;

    // Job-level reference model, evaluated and compared once per cycle
    bit              m_busy;
    int              m_owner, m_ptr, m_start_at, m_resp_at, m_win;
    logic [OW-1:0]   m_m, m_q;
    logic [RW-1:0]   m_res;
    logic [NREQ-1:0] e_gnt, e_valid;
    logic            e_start;

    always @(negedge clk) begin
        if (!n_rst) begin
            m_busy = 1'b0;
            m_ptr  = NREQ - 1;
            chk("rst_gnt", gnt, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_mul_start", mul_start, 0);
            chk("rst_mul_m", mul_m, 0);
            chk("rst_mul_q", mul_q, 0);
            chk("rst_busy", busy, 0);
        end else begin
            e_gnt = '0; e_valid = '0; e_start = 1'b0; m_win = -1;
            if (m_busy) begin
                if (cyc == m_start_at) e_start = 1'b1;
                if (cyc >= m_resp_at)  e_valid[m_owner] = 1'b1;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_win < 0 && req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                end
                if (m_win >= 0) e_gnt[m_win] = 1'b1;
            end
            chk("model_gnt", gnt, e_gnt);
            chk("model_mul_start", mul_start, e_start);
            chk("model_busy", busy, m_busy);
            chk("model_rsp_valid", rsp_valid, e_valid);
            if (e_valid != 0) chk("model_rsp_result", rsp_result, m_res);
            if (e_start) begin
                chk("model_mul_m", mul_m, m_m);
                chk("model_mul_q", mul_q, m_q);
            end
            if (m_win >= 0) begin
                m_busy     = 1'b1;
                m_owner    = m_win;
                m_ptr      = m_win;
                m_m        = req_m[m_win*OW +: OW];
                m_q        = req_q[m_win*OW +: OW];
                m_res      = RW'(int'(m_m) * int'(m_q));
                m_start_at = cyc + 1;
                m_resp_at  = cyc + MUL_LAT + 2;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
                if (m_m == 0 || m_q == 0) begin
                    m_res      = '0;
                    m_start_at = -1;
                    m_resp_at  = cyc + 1;
                end
`endif
            end else if (m_busy && e_valid != 0 && rsp_ready[m_owner]) begin
                m_busy = 1'b0;
            end
        end
    end

    // One job on requester i with rsp_ready held high.
    // Records the cycles of grant, mul_start and response.
    task automatic run_job(input int i, input logic [OW-1:0] m, input logic [OW-1:0] q,
                           output int t_g, output int t_s, output int t_v,
                           output logic [RW-1:0] res);
        t_g = -1; t_s = -1; t_v = -1; res = '0;
        req_m[i*OW +: OW] = m;
        req_q[i*OW +: OW] = q;
        req[i] = 1'b1;
        rsp_ready[i] = 1'b1;
        for (int k = 0; k < 60 && t_v < 0; k++) begin
            @(negedge clk);
            if (gnt[i] && t_g < 0) t_g = cyc;
            if (mul_start && t_s < 0) t_s = cyc;
            if (rsp_valid[i]) begin t_v = cyc; res = rsp_result; end
            @(posedge clk); #1;
            if (t_g >= 0) req[i] = 1'b0;
        end
        req[i] = 1'b0;
        rsp_ready[i] = 1'b0;
        $display("job req=%0d m=%0d q=%0d gnt@%0d start@%0d rsp@%0d result=%0d", i, m, q, t_g, t_s, t_v, res);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 60 && !idle; k++) begin
            @(negedge clk);
            idle = !busy;
            @(posedge clk); #1;
        end
        chk("idle_reached", idle, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tg, ts, tv;
        logic [RW-1:0] res;
        bit seen, stable;
        logic [NREQ-1:0] g_list[$];
        int c_list[$];

        n_rst = 1'b0; req = '0; req_m = '0; req_q = '0; rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        // 1: single job, m=3, q=2 -> result 6 at T+8
        run_job(0, 5'd3, 5'd2, tg, ts, tv, res);
        chk("t1_gnt_seen", (tg >= 0), 1);
        chk("t1_start_lat", ts - tg, 1);
        chk("t1_rsp_lat", tv - tg, MUL_LAT + 2);
        chk("t1_result", res, 8'd6);

        // 2: all four requesting after a reset -> order 0,1,2,3,0 every 9 cycles
        n_rst = 1'b0;
        @(posedge clk); #1 n_rst = 1'b1;
        req_m = {5'd4, 5'd3, 5'd2, 5'd1};
        req_q = {5'd8, 5'd7, 5'd6, 5'd5};
        rsp_ready = '1;
        req = '1;
        for (int k = 0; k < 200 && g_list.size() < 5; k++) begin
            @(negedge clk);
            if (gnt != 0) begin
                g_list.push_back(gnt);
                c_list.push_back(cyc);
                $display("rr grant %0b at cycle %0d", gnt, cyc);
            end
        end
        @(posedge clk); #1 req = '0;
        wait_idle();
        rsp_ready = '0;
        chk("t2_count", g_list.size(), 5);
        chk("t2_order0", g_list[0], 4'b0001);
        chk("t2_order1", g_list[1], 4'b0010);
        chk("t2_order2", g_list[2], 4'b0100);
        chk("t2_order3", g_list[3], 4'b1000);
        chk("t2_order4", g_list[4], 4'b0001);
        for (int k = 1; k < 5; k++) chk("t2_gap", c_list[k] - c_list[k-1], MUL_LAT + 3);

        // 3: response stalled (not ready, then only non-owners ready) with a competing request
        req_m[1*OW +: OW] = 5'd7; req_q[1*OW +: OW] = 5'd9;
        req_m[2*OW +: OW] = 5'd2; req_q[2*OW +: OW] = 5'd3;
        req[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (gnt[1]) begin seen = 1'b1; break; end
        end
        chk("t3_gnt_seen", seen, 1);
        @(posedge clk); #1 req[1] = 1'b0; req[2] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin seen = 1'b1; break; end
        end
        chk("t3_valid", rsp_valid, 4'b0010);
        chk("t3_result", rsp_result, 8'd63);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1 rsp_ready = (k < 5) ? 4'b0000 : 4'b1101;
            @(negedge clk);
            if (rsp_valid != 4'b0010 || rsp_result != 8'd63 || gnt != 0 || mul_start) stable = 1'b0;
        end
        chk("t3_stall_stable", stable, 1);
        $display("stall done valid=%0b result=%0d", rsp_valid, rsp_result);
        @(posedge clk); #1 rsp_ready = 4'b0010;
        @(negedge clk);
        @(posedge clk); #1 rsp_ready = '0;
        @(negedge clk);
        chk("t3_next_gnt", gnt, 4'b0100);
        @(posedge clk); #1 req[2] = 1'b0; rsp_ready = 4'b0100;
        wait_idle();
        rsp_ready = '0;

        // 4: reset in WAIT abandons the job, and the pointer restarts so requester 0 wins
        req_m[0*OW +: OW] = 5'd5; req_q[0*OW +: OW] = 5'd6;
        req[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mul_start) begin seen = 1'b1; break; end
        end
        chk("t4_start_seen", seen, 1);
        @(posedge clk); #1 req = 4'b0101;
        @(posedge clk); #1 n_rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_gnt", gnt, 0);
        $display("reset in WAIT busy=%0b gnt=%0b", busy, gnt);
        @(posedge clk); #1 n_rst = 1'b1; rsp_ready = '1;
        @(negedge clk);
        chk("t4_ptr_reset", gnt, 4'b0001);
        @(posedge clk); #1 req[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (gnt[2]) begin seen = 1'b1; break; end
        end
        chk("t4_gnt2_seen", seen, 1);
        @(posedge clk); #1 req = '0;
        wait_idle();
        rsp_ready = '0;

        // 5: zero multiplicand
        run_job(1, 5'd0, 5'd7, tg, ts, tv, res);
        chk("t5_result", res, 8'd0);
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
        chk("t5_rsp_lat", tv - tg, 1);
        chk("t5_no_start", ts, -1);
`else
        chk("t5_rsp_lat", tv - tg, MUL_LAT + 2);
        chk("t5_start_lat", ts - tg, 1);
`endif
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
